// File: rtl/perm_stream_checker_pkg.sv
// Shared definitions for perm_stream_checker: FSM state encoding and the
// packed-slot extract macro used to address one W-bit slot of the IMAP bus.
// Optional feature macro (see top file): PERM_STREAM_CHECKER_DUP_IDX_EN.
`ifndef PERM_SLOT
`define PERM_SLOT(bus, v, W) bus[(v)*(W) +: (W)]
`endif

package perm_stream_checker_pkg;

  // COLLECT accepts elements, DONE presents the frame result.
  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_DONE    = 1'b1
  } state_e;

endpackage

// File: rtl/perm_slot_bank.sv
// N x W slot register file for the inverse map. Slot v stores the arrival
// index of value v; a per-slot seen bit records whether v has been written.
// A clear zeroes both the slots and the seen bitmap in one edge.
module perm_slot_bank #(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr_i,
  input  logic           we_i,
  input  logic [W-1:0]   v_i,
  input  logic [W-1:0]   idx_i,
  output logic [N-1:0]   seen_o,
  output logic [N*W-1:0] imap_o
);

  for (genvar gi = 0; gi < N; gi++) begin : g_slot
    logic [W-1:0] slot_q;
    logic         seen_q;

    // Slot gi latches the arrival index on its first write; reset and clear zero it.
    always_ff @(posedge clk) begin
      if (!rst_n || clr_i) begin
        slot_q <= '0;
        seen_q <= 1'b0;
      end else if (we_i && (v_i == W'(gi))) begin
        slot_q <= idx_i;
        seen_q <= 1'b1;
      end
    end

    assign `PERM_SLOT(imap_o, gi, W) = slot_q;
    assign seen_o[gi] = seen_q;
  end

endmodule

// File: rtl/perm_stream_checker.sv
// Streaming permutation checker: collects N elements one per handshake,
// reports whether they form a permutation of 0..N-1 and exposes the packed
// inverse map (first occurrence wins, unseen slots read 0).
// Optional macro PERM_STREAM_CHECKER_DUP_IDX_EN adds the DUP_IDX output,
// the arrival index of the first duplicate element in the frame.
module perm_stream_checker
  import perm_stream_checker_pkg::*;
#(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic           IN_VALID,
  output logic           IN_READY,
  input  logic [W-1:0]   IN_DATA,
  output logic           OUT_VALID,
  input  logic           OUT_READY,
  output logic           VALID,
  output logic [N*W-1:0] IMAP
`ifdef PERM_STREAM_CHECKER_DUP_IDX_EN
  ,
  output logic [W-1:0]   DUP_IDX
`endif
);

  localparam logic [W:0] LAST_IDX = (W+1)'(N-1);

  state_e       state_q, state_d;
  logic [W:0]   cnt_q, cnt_d;
  logic         dup_q, dup_d;
  logic         valid_q, valid_d;
  logic [N-1:0] seen;
  logic         accept;
  logic         rel;
  logic         hit;

`ifdef PERM_STREAM_CHECKER_DUP_IDX_EN
  logic [W-1:0] dup_idx_q, dup_idx_d;
`endif

  // Handshakes depend only on registered state plus the peer's valid/ready.
  assign IN_READY  = (state_q == ST_COLLECT);
  assign OUT_VALID = (state_q == ST_DONE);
  assign accept    = IN_VALID && IN_READY;
  assign rel       = OUT_READY && OUT_VALID;
  assign hit       = seen[IN_DATA];

  perm_slot_bank #(
    .N(N)
  ) u_bank (
    .clk    (CLK),
    .rst_n  (RST_N),
    .clr_i  (rel),
    .we_i   (accept && !hit),
    .v_i    (IN_DATA),
    .idx_i  (cnt_q[W-1:0]),
    .seen_o (seen),
    .imap_o (IMAP)
  );

  // Next-state: count accepts, track duplicates, latch the verdict on the last element.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dup_d   = dup_q;
    valid_d = valid_q;
`ifdef PERM_STREAM_CHECKER_DUP_IDX_EN
    dup_idx_d = dup_idx_q;
`endif
    if (accept) begin
      cnt_d = cnt_q + {{W{1'b0}}, 1'b1};
      if (hit) begin
        dup_d = 1'b1;
`ifdef PERM_STREAM_CHECKER_DUP_IDX_EN
        if (!dup_q) begin
          dup_idx_d = cnt_q[W-1:0];
        end
`endif
      end
      if (cnt_q == LAST_IDX) begin
        state_d = ST_DONE;
        valid_d = !(dup_q || hit);
`ifdef PERM_STREAM_CHECKER_DUP_IDX_EN
        if (!(dup_q || hit)) begin
          dup_idx_d = '0;
        end
`endif
      end
    end
    if (rel) begin
      state_d = ST_COLLECT;
      cnt_d   = '0;
      dup_d   = 1'b0;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= ST_COLLECT;
      cnt_q   <= '0;
      dup_q   <= 1'b0;
      valid_q <= 1'b0;
`ifdef PERM_STREAM_CHECKER_DUP_IDX_EN
      dup_idx_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dup_q   <= dup_d;
      valid_q <= valid_d;
`ifdef PERM_STREAM_CHECKER_DUP_IDX_EN
      dup_idx_q <= dup_idx_d;
`endif
    end
  end

  assign VALID = valid_q;
`ifdef PERM_STREAM_CHECKER_DUP_IDX_EN
  assign DUP_IDX = dup_idx_q;
`endif

endmodule

// File: tb/tb_perm_stream_checker.sv
// Directed bench for perm_stream_checker (N=4): reference frames, backpressure,
// bubbles, mid-frame reset and an exhaustive sweep of all 4-tuples.
// DUP_IDX is checked when PERM_STREAM_CHECKER_DUP_IDX_EN is defined.
module tb_perm_stream_checker;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       IN_VALID = 1'b0;
  logic       IN_READY;
  logic [1:0] IN_DATA = 2'd0;
  logic       OUT_VALID;
  logic       OUT_READY = 1'b0;
  logic       VALID;
  logic [7:0] IMAP;
`ifdef PERM_STREAM_CHECKER_DUP_IDX_EN
  logic [1:0] DUP_IDX;
`endif

  int n_cmp = 0;
  int n_err = 0;

  perm_stream_checker #(
    .N(4)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .IN_DATA   (IN_DATA),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .VALID     (VALID),
    .IMAP      (IMAP)
`ifdef PERM_STREAM_CHECKER_DUP_IDX_EN
    ,
    .DUP_IDX   (DUP_IDX)
`endif
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // One accepted element: IN_READY must be high before the edge.
  task automatic put(input string tag, input logic [1:0] v);
    IN_VALID = 1'b1;
    IN_DATA  = v;
    check({tag, ".in_ready"}, 32'(IN_READY), 32'd1);
    step();
    IN_VALID = 1'b0;
  endtask

  task automatic frame(input string tag, input logic [1:0] a, input logic [1:0] b,
                       input logic [1:0] c, input logic [1:0] d);
    put(tag, a);
    put(tag, b);
    put(tag, c);
    put(tag, d);
  endtask

  task automatic expect_result(input string tag, input logic v, input logic [7:0] imap,
                               input logic [1:0] dup_idx);
    $display("frame %s: VALID=%0d IMAP=%02h", tag, VALID, IMAP);
    check({tag, ".out_valid"}, 32'(OUT_VALID), 32'd1);
    check({tag, ".in_ready_done"}, 32'(IN_READY), 32'd0);
    check({tag, ".valid"}, 32'(VALID), 32'(v));
    check({tag, ".imap"}, 32'(IMAP), 32'(imap));
`ifdef PERM_STREAM_CHECKER_DUP_IDX_EN
    check({tag, ".dup_idx"}, 32'(DUP_IDX), 32'(dup_idx));
`else
    if (dup_idx != 2'd0 && n_cmp < 0) $display("unused dup_idx");
`endif
  endtask

  task automatic release_result(input string tag);
    OUT_READY = 1'b1;
    step();
    OUT_READY = 1'b0;
    check({tag, ".rel_in_ready"}, 32'(IN_READY), 32'd1);
    check({tag, ".rel_out_valid"}, 32'(OUT_VALID), 32'd0);
  endtask

  // Reference: first occurrence wins, unseen slots 0, dup index = first repeat.
  task automatic ref_model(input logic [7:0] t, output logic v, output logic [7:0] imap,
                           output logic [1:0] dup_idx);
    logic [3:0] seen_m;
    logic       dup_m;
    logic [1:0] e;
    seen_m  = 4'd0;
    dup_m   = 1'b0;
    imap    = 8'd0;
    dup_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      e = t[i*2 +: 2];
      if (seen_m[e]) begin
        if (!dup_m) dup_idx = 2'(i);
        dup_m = 1'b1;
      end else begin
        seen_m[e] = 1'b1;
        imap[e*2 +: 2] = 2'(i);
      end
    end
    v = !dup_m;
  endtask

  initial begin
    logic [7:0] t;
    logic       rv;
    logic [7:0] rimap;
    logic [1:0] rdup;

    // Reset
    step();
    step();
    RST_N = 1'b1;
    check("reset.in_ready", 32'(IN_READY), 32'd1);
    check("reset.out_valid", 32'(OUT_VALID), 32'd0);
    check("reset.valid", 32'(VALID), 32'd0);
    check("reset.imap", 32'(IMAP), 32'd0);
`ifdef PERM_STREAM_CHECKER_DUP_IDX_EN
    check("reset.dup_idx", 32'(DUP_IDX), 32'd0);
`endif

    // Reference frames
    frame("p2031", 2'd2, 2'd0, 2'd3, 2'd1);
    expect_result("p2031", 1'b1, 8'h8D, 2'd0);
    release_result("p2031");

    frame("p0123", 2'd0, 2'd1, 2'd2, 2'd3);
    expect_result("p0123", 1'b1, 8'hE4, 2'd0);
    release_result("p0123");

    frame("d1123", 2'd1, 2'd1, 2'd2, 2'd3);
    expect_result("d1123", 1'b0, 8'hE0, 2'd1);
    release_result("d1123");

    // Backpressure: results hold and inputs are refused while OUT_READY=0
    frame("bp", 2'd0, 2'd1, 2'd2, 2'd3);
    for (int k = 0; k < 5; k++) begin
      IN_VALID = 1'b1;
      IN_DATA  = 2'(k);
      step();
      $display("bp cycle %0d: IN_READY=%0d VALID=%0d IMAP=%02h", k, IN_READY, VALID, IMAP);
      check("bp.in_ready", 32'(IN_READY), 32'd0);
      check("bp.out_valid", 32'(OUT_VALID), 32'd1);
      check("bp.valid", 32'(VALID), 32'd1);
      check("bp.imap", 32'(IMAP), 32'hE4);
    end
    IN_VALID = 1'b0;
    release_result("bp");

    // Bubbles: only IN_VALID beats count; bubble data would create duplicates
    IN_VALID = 1'b1; IN_DATA = 2'd3; step();
    IN_VALID = 1'b0; IN_DATA = 2'd3; step();
    IN_VALID = 1'b1; IN_DATA = 2'd2; step();
    IN_VALID = 1'b0; IN_DATA = 2'd2; step();
    IN_VALID = 1'b1; IN_DATA = 2'd1; step();
    IN_VALID = 1'b0; IN_DATA = 2'd1; step();
    check("bub.not_done", 32'(OUT_VALID), 32'd0);
    IN_VALID = 1'b1; IN_DATA = 2'd0; step();
    IN_VALID = 1'b0;
    expect_result("bub", 1'b1, 8'h1B, 2'd0);
    release_result("bub");

    // Reset mid-frame discards partial elements
    put("rst", 2'd3);
    put("rst", 2'd3);
    RST_N = 1'b0;
    step();
    RST_N = 1'b1;
    check("rst.imap_cleared", 32'(IMAP), 32'd0);
    check("rst.out_valid", 32'(OUT_VALID), 32'd0);
    frame("rst", 2'd2, 2'd0, 2'd3, 2'd1);
    expect_result("rst", 1'b1, 8'h8D, 2'd0);
    release_result("rst");

    // Exhaustive sweep, OUT_READY held high
    OUT_READY = 1'b1;
    for (int k = 0; k < 256; k++) begin
      t = 8'(k);
      ref_model(t, rv, rimap, rdup);
      frame("ex", t[1:0], t[3:2], t[5:4], t[7:6]);
      expect_result($sformatf("ex%0d", k), rv, rimap, rdup);
      step();
      check("ex.next_ready", 32'(IN_READY), 32'd1);
    end
    OUT_READY = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
